// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: handshake and operand/result bundle between the EX
// stage (master) and the iterative multiply/divide unit (slave).
interface muldiv_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, stall_req, done, result
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, stall_req, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned multiply (shift-add) / divide
// (restoring) unit beside the EX-stage ALU. One op is accepted in IDLE,
// sequenced over WIDTH RUN cycles, and reported with a one-cycle done pulse
// in DONE. The pipeline is held through stall_req while the unit works.
//
// Optional build macro MULDIV_EARLY_OUT_EN: when defined, an accepted op with
// a zero operand skips RUN and goes straight to DONE with the same result the
// full iteration would produce.
module muldiv_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    muldiv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0]       OP_MUL   = 2'b00;
    localparam logic [1:0]       OP_MULH  = 2'b01;
    localparam logic [1:0]       OP_DIVU  = 2'b10;
    localparam logic [1:0]       OP_REMU  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [1:0]             op_r;
    logic [WIDTH-1:0]       mcand_r;     // multiplicand
    logic [WIDTH-1:0]       divisor_r;
    logic [2*WIDTH-1:0]     prod_r;      // upper: partial sum, lower: multiplier
    logic [WIDTH-1:0]       rem_r;       // partial remainder
    logic [WIDTH-1:0]       quo_r;       // dividend bits shifting out, quotient shifting in
    logic [WIDTH-1:0]       result_r;

    logic                   accept_s;
    logic [WIDTH:0]         add_s;
    logic [2*WIDTH-1:0]     prod_nxt_s;
    logic [WIDTH:0]         shifted_s;
    logic [WIDTH:0]         trial_s;
    logic [WIDTH-1:0]       rem_nxt_s;
    logic [WIDTH-1:0]       quo_nxt_s;
    logic [WIDTH-1:0]       run_res_s;

`ifdef MULDIV_EARLY_OUT_EN
    logic                   early_s;
    logic [WIDTH-1:0]       early_res_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
    // Short-cut result for a zero operand, matching the full iteration.
    always_comb begin
        early_s     = (bus.operand_a == {WIDTH{1'b0}}) || (bus.operand_b == {WIDTH{1'b0}});
        early_res_s = {WIDTH{1'b0}};
        case (bus.op)
            OP_MUL, OP_MULH: early_res_s = {WIDTH{1'b0}};
            OP_DIVU: begin
                if (bus.operand_b == {WIDTH{1'b0}}) begin
                    early_res_s = {WIDTH{1'b1}};
                end else begin
                    early_res_s = {WIDTH{1'b0}};
                end
            end
            OP_REMU: begin
                if (bus.operand_b == {WIDTH{1'b0}}) begin
                    early_res_s = bus.operand_a;
                end else begin
                    early_res_s = {WIDTH{1'b0}};
                end
            end
            default: early_res_s = {WIDTH{1'b0}};
        endcase
    end
`endif

    // One multiply and one divide iteration, plus the result they would yield.
    always_comb begin
        // Multiply: conditional add into the upper half, then shift right
        // with the adder carry entering the top bit.
        if (prod_r[0]) begin
            add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        prod_nxt_s = {add_s, prod_r[WIDTH-1:1]};

        // Restoring divide: bring down the next dividend bit, trial-subtract.
        // The partial remainder is always below the divisor, so WIDTH+1 bits
        // hold the shifted value and bit WIDTH of the difference is its sign.
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor_r};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
        end

        case (op_r)
            OP_MUL:  run_res_s = prod_nxt_s[WIDTH-1:0];
            OP_MULH: run_res_s = prod_nxt_s[2*WIDTH-1:WIDTH];
            OP_DIVU: run_res_s = quo_nxt_s;
            OP_REMU: run_res_s = rem_nxt_s;
            default: run_res_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
`else
                    state_nxt_s = ST_RUN;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stall covers the accepting cycle and RUN, never DONE,
    // and a flush during DONE suppresses the done pulse.
    always_comb begin
        bus.busy      = 1'b0;
        bus.stall_req = 1'b0;
        bus.done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus.stall_req = bus.start && !bus.flush;
            end
            ST_RUN: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = !bus.flush;
            end
            default: begin
                bus.busy      = 1'b0;
                bus.stall_req = 1'b0;
                bus.done      = 1'b0;
            end
        endcase
    end

    // Operand latch, iteration datapath, counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= CNT_ZERO;
            op_r      <= 2'b00;
            mcand_r   <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            prod_r    <= {(2*WIDTH){1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            result_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= CNT_ZERO;
                        op_r      <= bus.op;
                        mcand_r   <= bus.operand_a;
                        divisor_r <= bus.operand_b;
                        prod_r    <= {{WIDTH{1'b0}}, bus.operand_b};
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= bus.operand_a;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_s) begin
                            result_r <= early_res_s;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        prod_r <= prod_nxt_s;
                        rem_r  <= rem_nxt_s;
                        quo_r  <= quo_nxt_s;
                        if (cnt_r == CNT_LAST) begin
                            result_r <= run_res_s;
                        end
                    end
                end
                ST_DONE: begin
                    cnt_r <= CNT_ZERO;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer.
// Expected zero-operand latency follows MULDIV_EARLY_OUT_EN when defined.
module tb_muldiv_sequencer;

    localparam int W = 8;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZLAT   = 1;
    localparam int ZSTALL = 1;
`else
    localparam int ZLAT   = 9;
    localparam int ZSTALL = 9;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    int         lat;
    int         stalls;
    int         dones;
    logic [W-1:0] res;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and watch a fixed window: latency counts edges from the
    // start edge through the edge entering DONE; stalls counts stall cycles
    // before done; dones counts done pulses in the window.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int l, output int s, output int d, output logic [W-1:0] r);
        int cyc;
        l = 0; s = 0; d = 0; r = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        #1;
        if (bus.stall_req) s++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                d++;
                if (d == 1) begin
                    l = cyc;
                    r = bus.result;
                end
            end else if (d == 0 && bus.stall_req) begin
                s++;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0; bus.flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   bus.busy,      1'b0);
        check("rst_stall",  bus.stall_req, 1'b0);
        check("rst_done",   bus.done,      1'b0);
        check("rst_result", bus.result,    8'h00);
        @(negedge clk); rst_n = 1'b1;

        // MUL 13*11 = 0x8F, 9-cycle latency, 9 stall cycles
        run_op(2'b00, 8'd13, 8'd11, lat, stalls, dones, res);
        check("mul_res",    res,    8'h8F);
        check("mul_lat",    lat,    9);
        check("mul_stall",  stalls, 9);
        check("mul_dones",  dones,  1);

        // MULH / MUL 200*200 = 0x9C40
        run_op(2'b01, 8'd200, 8'd200, lat, stalls, dones, res);
        check("mulh_res",   res, 8'h9C);
        run_op(2'b00, 8'd200, 8'd200, lat, stalls, dones, res);
        check("mul_lo_res", res, 8'h40);

        // DIVU / REMU 200/7 = 28 r 4, result holds between ops
        run_op(2'b10, 8'd200, 8'd7, lat, stalls, dones, res);
        check("divu_res",   res,   8'h1C);
        check("divu_dones", dones, 1);
        check("divu_hold",  bus.result, 8'h1C);
        run_op(2'b11, 8'd200, 8'd7, lat, stalls, dones, res);
        check("remu_res",   res,   8'h04);
        check("remu_dones", dones, 1);

        // Operand extremes
        run_op(2'b01, 8'hFF, 8'hFF, lat, stalls, dones, res);
        check("mulh_max",   res, 8'hFE);
        run_op(2'b11, 8'd7, 8'd9, lat, stalls, dones, res);
        check("remu_small", res, 8'h07);
        run_op(2'b10, 8'hFF, 8'd1, lat, stalls, dones, res);
        check("divu_by1",   res, 8'hFF);

        // Zero operands
        run_op(2'b10, 8'h55, 8'h00, lat, stalls, dones, res);
        check("div0_res",   res, 8'hFF);
        check("div0_lat",   lat, ZLAT);
        run_op(2'b00, 8'h00, 8'd77, lat, stalls, dones, res);
        check("mulz_res",   res,    8'h00);
        check("mulz_lat",   lat,    ZLAT);
        check("mulz_stall", stalls, ZSTALL);
        run_op(2'b11, 8'h55, 8'h00, lat, stalls, dones, res);
        check("rem0_res",   res, 8'h55);
        check("rem0_lat",   lat, ZLAT);

        // Flush together with start in IDLE: op dropped
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.operand_a = 8'd3; bus.operand_b = 8'd3;
        #1;
        check("fs_stall", bus.stall_req, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("fs_busy", bus.busy, 1'b0);

        // Flush on the 3rd RUN cycle: IDLE next, no done, result unchanged
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 8'd5; bus.operand_b = 8'd3;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bus.flush = 1'b1;
        check("fl_run_busy", bus.busy, 1'b1);
        @(posedge clk); #1; bus.flush = 1'b0;
        check("fl_idle_busy", bus.busy, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        check("fl_dones",  dones,      0);
        check("fl_result", bus.result, 8'h55);
        run_op(2'b10, 8'd9, 8'd3, lat, stalls, dones, res);
        check("fl_next_res", res, 8'h03);

        // start pulsed during RUN is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 8'd6; bus.operand_b = 8'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 8'd100; bus.operand_b = 8'd10;
        @(posedge clk); #1; bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        check("ign_dones",  dones,      1);
        check("ign_result", bus.result, 8'h2A);

        // Reset mid-RUN clears everything at once
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 8'd13; bus.operand_b = 8'd11;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",   bus.busy,      1'b0);
        check("mrst_stall",  bus.stall_req, 1'b0);
        check("mrst_done",   bus.done,      1'b0);
        check("mrst_result", bus.result,    8'h00);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_idle", bus.busy, 1'b0);
        run_op(2'b10, 8'd200, 8'd7, lat, stalls, dones, res);
        check("mrst_div_res", res, 8'h1C);
        check("mrst_div_lat", lat, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
